seg7_scan_ctrl: RTL

- Sequencing controller for the board's 8-digit, active-low, common-anode 7-segment display.
- Accepts a 32-bit binary value over a valid/ready handshake and converts it to 8 BCD digits with a sequential shift-add-3 (double-dabble) engine over 32 cycles.
- Commits the result to a display register, then time-multiplexes the 8 digits with leading-zero blanking and overflow indication.
- Sits between the processor's memory-mapped display register and the board's anode/cathode pins.

---
 rtl/seg7_scan_ctrl.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: binary-to-BCD conversion (double-dabble) plus a
// time-multiplexed scan driver for an 8-digit active-low 7-segment display.
module seg7_scan_ctrl #(
  parameter int unsigned REFRESH_LIMIT = 100000,
  parameter bit          BLANK_LEADING = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] in_value,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic [7:0]  catodes,
  output logic [7:0]  anodes
);

  localparam int unsigned VAL_W  = 32;
  localparam int unsigned CNT_W  = $clog2(REFRESH_LIMIT);
  localparam int unsigned SHFT_W = 5;
  localparam logic [CNT_W-1:0]  REFRESH_LAST = CNT_W'(REFRESH_LIMIT - 1);
  localparam logic [SHFT_W-1:0] SHIFT_LAST   = SHFT_W'(VAL_W - 1);
  localparam logic [VAL_W-1:0]  OVF_THRESH   = VAL_W'(100000000);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t              state;
  logic [VAL_W-1:0]    bin;
  logic [VAL_W-1:0]    bcd;
  logic [SHFT_W-1:0]   shift_cnt;
  logic                ovf_pend;
  logic [VAL_W-1:0]    disp;
  logic [CNT_W-1:0]    ref_cnt;
  logic [2:0]          idx;

  logic [2:0]          msd_c;
  logic [3:0]          digit_c;
  logic [7:0]          sel_c;
  logic                blank_c;

  // One double-dabble step: add 3 to every nibble >= 5, then shift {bcd, bin} left.
  function automatic logic [2*VAL_W-1:0] dd_step(input logic [VAL_W-1:0] acc,
                                                 input logic [VAL_W-1:0] src);
    logic [VAL_W-1:0] adj;
    adj = acc;
    for (int i = 0; i < 8; i++) begin
      if (acc[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
    return {adj, src} << 1;
  endfunction

  // Active-low segment pattern, decimal point held off.
  function automatic logic [7:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    return 8'hC0;
      4'd1:    return 8'hF9;
      4'd2:    return 8'hA4;
      4'd3:    return 8'hB0;
      4'd4:    return 8'h99;
      4'd5:    return 8'h92;
      4'd6:    return 8'h82;
      4'd7:    return 8'hF8;
      4'd8:    return 8'h80;
      4'd9:    return 8'h90;
      default: return 8'hBF;
    endcase
  endfunction

  // Conversion FSM: accept, shift 32 times, commit to the display register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      overflow  <= 1'b0;
      bin       <= '0;
      bcd       <= '0;
      shift_cnt <= '0;
      ovf_pend  <= 1'b0;
      disp      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            bin       <= in_value;
            bcd       <= '0;
            shift_cnt <= '0;
            ovf_pend  <= (in_value >= OVF_THRESH);
            in_ready  <= 1'b0;
            busy      <= 1'b1;
            state     <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          {bcd, bin} <= dd_step(bcd, bin);
          shift_cnt  <= shift_cnt + SHFT_W'(1);
          if (shift_cnt == SHIFT_LAST) state <= S_DONE;
        end
        S_DONE: begin
          disp     <= bcd;
          overflow <= ovf_pend;
          done     <= 1'b1;
          in_ready <= 1'b1;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Free-running refresh counter; the digit index advances at terminal count.
  always_ff @(posedge clk) begin
    if (reset) begin
      ref_cnt <= '0;
      idx     <= '0;
    end else if (ref_cnt == REFRESH_LAST) begin
      ref_cnt <= '0;
      idx     <= idx + 3'd1;
    end else begin
      ref_cnt <= ref_cnt + CNT_W'(1);
    end
  end

  // Most significant nonzero digit, current digit and its blanking decision.
  always_comb begin
    msd_c = '0;
    for (int i = 1; i < 8; i++) begin
      if (disp[4*i +: 4] != 4'd0) msd_c = 3'(i);
    end
    digit_c = disp[{idx, 2'b00} +: 4];
    sel_c   = ~(8'h01 << idx);
    blank_c = BLANK_LEADING && (idx > msd_c);
  end

  // Registered pin drive: overflow shows all 9s, blanked slots turn everything off.
  always_ff @(posedge clk) begin
    if (reset) begin
      anodes  <= 8'hFF;
      catodes <= 8'hFF;
    end else if (overflow) begin
      anodes  <= sel_c;
      catodes <= 8'h90;
    end else if (blank_c) begin
      anodes  <= 8'hFF;
      catodes <= 8'hFF;
    end else begin
      anodes  <= sel_c;
      catodes <= seg_code(digit_c);
    end
  end

endmodule
